// File: rtl/seg2_bcd_display.sv
// Two-digit common-anode 7-segment back-end: converts a 0-99 binary count to BCD
// with a serial shift-add-3 engine and multiplexes the digits onto the display.
module seg2_bcd_display #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [6:0] value,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       ovf,
  output logic       busy
);

  localparam int unsigned VAL_W  = 7;
  localparam int unsigned BCD_W  = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned RCNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [VAL_W-1:0]  VAL_MAX    = VAL_W'(99);
  localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(VAL_W - 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST  = RCNT_W'(REFRESH_DIV - 1);
  localparam logic [SEG_W-1:0]  SEG_BLANK  = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [VAL_W-1:0]   shreg;
  logic [BCD_W-1:0]   scratch;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_next;
  logic [NIB_W-1:0]   tens;
  logic [NIB_W-1:0]   ones;
  logic [RCNT_W-1:0]  rcnt;
  logic               sel;

  logic [BCD_W-1:0]   bcd_adj;
  logic [VAL_W-1:0]   value_clamped;
  logic [NIB_W-1:0]   digit;
  logic               blank;

  // Active-low {g,f,e,d,c,b,a} patterns; non-decimal nibbles stay dark.
  function automatic logic [SEG_W-1:0] decode(input logic [NIB_W-1:0] d);
    logic [SEG_W-1:0] s;
    s = SEG_BLANK;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add-3 correction applied to each BCD nibble before every shift.
  always_comb begin
    bcd_adj = scratch;
    if (scratch[3:0] >= 4'd5) bcd_adj[3:0] = scratch[3:0] + 4'd3;
    if (scratch[7:4] >= 4'd5) bcd_adj[7:4] = scratch[7:4] + 4'd3;
  end

  assign value_clamped = (value > VAL_MAX) ? VAL_MAX : value;

  // Converter FSM: IDLE captures, SHIFT runs seven double-dabble steps, DONE publishes.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_next <= 1'b0;
      tens     <= '0;
      ones     <= '0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          shreg    <= value_clamped;
          scratch  <= '0;
          ovf_next <= (value > VAL_MAX);
          cnt      <= '0;
          busy     <= 1'b1;
          state    <= SHIFT;
        end
        SHIFT: begin
          scratch <= {bcd_adj[BCD_W-2:0], shreg[VAL_W-1]};
          shreg   <= {shreg[VAL_W-2:0], 1'b0};
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST_SHIFT) state <= DONE;
        end
        DONE: begin
          tens  <= scratch[7:4];
          ones  <= scratch[3:0];
          ovf   <= ovf_next;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Refresh divider: each digit stays lit for REFRESH_DIV cycles.
  always_ff @(posedge CLK) begin
    if (rst) begin
      rcnt <= '0;
      sel  <= 1'b0;
    end else if (rcnt == RCNT_LAST) begin
      rcnt <= '0;
      sel  <= ~sel;
    end else begin
      rcnt <= rcnt + RCNT_W'(1);
    end
  end

  assign digit = sel ? tens : ones;
  assign blank = BLANK_LZ && sel && (tens == '0);

  // Segment and anode drive share one register so they switch on the same edge.
  always_ff @(posedge CLK) begin
    if (rst) begin
      seg <= 7'h40;
      an  <= 2'b10;
    end else begin
      seg <= blank ? SEG_BLANK : decode(digit);
      an  <= sel ? 2'b01 : 2'b10;
    end
  end

endmodule
